// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width and one-hot ALU function codes.
// Compare/branch functions sit in the upper bits and need FW >= 15 to be expressible.
package cpu_pkg;

  localparam int CPU_XLEN = 32;
  localparam int ALU_FN_W = 15;

  localparam logic [ALU_FN_W-1:0] ALU_ADD  = 15'h0001;
  localparam logic [ALU_FN_W-1:0] ALU_SUB  = 15'h0002;
  localparam logic [ALU_FN_W-1:0] ALU_SLT  = 15'h0004;
  localparam logic [ALU_FN_W-1:0] ALU_SLTU = 15'h0008;
  localparam logic [ALU_FN_W-1:0] ALU_AND  = 15'h0010;
  localparam logic [ALU_FN_W-1:0] ALU_OR   = 15'h0020;
  localparam logic [ALU_FN_W-1:0] ALU_NOR  = 15'h0040;
  localparam logic [ALU_FN_W-1:0] ALU_XOR  = 15'h0080;
  localparam logic [ALU_FN_W-1:0] ALU_SLL  = 15'h0100;
  localparam logic [ALU_FN_W-1:0] ALU_SRL  = 15'h0200;
  localparam logic [ALU_FN_W-1:0] ALU_SRA  = 15'h0400;
  localparam logic [ALU_FN_W-1:0] ALU_EQ   = 15'h0800;
  localparam logic [ALU_FN_W-1:0] ALU_NE   = 15'h1000;
  localparam logic [ALU_FN_W-1:0] ALU_GE   = 15'h2000;
  localparam logic [ALU_FN_W-1:0] ALU_GEU  = 15'h4000;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute operand stage bundle: decode fields, pipeline control, forwarding
// sources and the ALU/downstream results. master = pipeline side, slave = the stage.
interface ex_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int FW   = 12
);
  logic            id_valid;
  logic [FW-1:0]   id_alu_f;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_use_imm;
  logic            id_use_pc;
  logic            id_reg_we;
  logic            id_is_load;

  logic            stall;
  logic            flush;

  logic [4:0]      exmem_rd;
  logic            exmem_we;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_we;
  logic [XLEN-1:0] memwb_result;

  logic [FW-1:0]   alu_f;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_we;
  logic            ex_is_load;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_stall;

  modport master (
    output id_valid, id_alu_f, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_rs1, id_rs2, id_rd, id_use_imm, id_use_pc, id_reg_we, id_is_load,
           stall, flush,
           exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
    input  alu_f, alu_a, alu_b, ex_valid, ex_rd, ex_reg_we, ex_is_load,
           ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_alu_f, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_rs1, id_rs2, id_rd, id_use_imm, id_use_pc, id_reg_we, id_is_load,
           stall, flush,
           exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
    output alu_f, alu_a, alu_b, ex_valid, ex_rd, ex_reg_we, ex_is_load,
           ex_store_data, load_use_stall
  );
endinterface

// File: rtl/fwd_mux.sv
// Source-operand bypass select: EX/MEM beats MEM/WB beats register file; x0 always reads 0.
// Purely combinational, zero latency, no backpressure.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  logic [4:0]      src,
  input  logic [XLEN-1:0] rs_data,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_we,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_we,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);

  // src != 0 is checked first, so a match below implies a nonzero producer rd.
  always_comb begin
    fwd_data = rs_data;
    if (src == 5'd0)
      fwd_data = '0;
    else if (exmem_we && (exmem_rd == src))
      fwd_data = exmem_result;
    else if (memwb_we && (memwb_rd == src))
      fwd_data = memwb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// One cycle ID->ALU latency; stall holds, flush or load-use inserts a bubble.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int FW   = 12
) (
  input logic                clk,
  input logic                rst_n,
  ex_operand_stage_if.slave  io
);

  typedef struct packed {
    logic            valid;
    logic [FW-1:0]   f;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            use_imm;
    logic            use_pc;
    logic            reg_we;
    logic            is_load;
  } ex_reg_t;

  ex_reg_t         ex_q;
  ex_reg_t         id_in;
  ex_reg_t         bubble;
  logic            f_ok;
  logic            load_use_stall;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A code with more than one bit set is dropped to 0 so the ALU idles on it.
  assign f_ok = ((io.id_alu_f & (io.id_alu_f - FW'(1))) == '0);

  always_comb begin
    id_in          = '0;
    id_in.valid    = io.id_valid;
    id_in.f        = f_ok ? io.id_alu_f : '0;
    id_in.rs1      = io.id_rs1;
    id_in.rs2      = io.id_rs2;
    id_in.rd       = io.id_rd;
    id_in.rs1_data = io.id_rs1_data;
    id_in.rs2_data = io.id_rs2_data;
    id_in.imm      = io.id_imm;
    id_in.pc       = io.id_pc;
    id_in.use_imm  = io.id_use_imm;
    id_in.use_pc   = io.id_use_pc;
    id_in.reg_we   = io.id_reg_we;
    id_in.is_load  = io.id_is_load;

    bubble         = id_in;
    bubble.valid   = 1'b0;
    bubble.f       = '0;
    bubble.reg_we  = 1'b0;
    bubble.is_load = 1'b0;
  end

  // Load data is not available until MEM, so a dependent ID instruction must wait one cycle.
  assign load_use_stall = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && io.id_valid &&
                          ((ex_q.rd == io.id_rs1) ||
                           (!io.id_use_imm && (ex_q.rd == io.id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ex_q <= '0;
    else if (io.flush)
      ex_q <= bubble;
    else if (!io.stall)
      ex_q <= load_use_stall ? bubble : id_in;
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .src          (ex_q.rs1),
    .rs_data      (ex_q.rs1_data),
    .exmem_rd     (io.exmem_rd),
    .exmem_we     (io.exmem_we),
    .exmem_result (io.exmem_result),
    .memwb_rd     (io.memwb_rd),
    .memwb_we     (io.memwb_we),
    .memwb_result (io.memwb_result),
    .fwd_data     (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .src          (ex_q.rs2),
    .rs_data      (ex_q.rs2_data),
    .exmem_rd     (io.exmem_rd),
    .exmem_we     (io.exmem_we),
    .exmem_result (io.exmem_result),
    .memwb_rd     (io.memwb_rd),
    .memwb_we     (io.memwb_we),
    .memwb_result (io.memwb_result),
    .fwd_data     (rs2_fwd)
  );

  assign io.alu_f          = ex_q.valid ? ex_q.f : '0;
  assign io.alu_a          = ex_q.use_pc ? ex_q.pc : rs1_fwd;
  assign io.alu_b          = ex_q.use_imm ? ex_q.imm : rs2_fwd;
  assign io.ex_store_data  = rs2_fwd;
  assign io.ex_valid       = ex_q.valid;
  assign io.ex_rd          = ex_q.rd;
  assign io.ex_reg_we      = ex_q.reg_we;
  assign io.ex_is_load     = ex_q.is_load;
  assign io.load_use_stall = load_use_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding vector table plus hazard/stall/reset sequences.
module tb_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_operand_stage_if #(.XLEN(32), .FW(12)) io ();

  ex_operand_stage #(.XLEN(32), .FW(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] f;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        use_imm;
    logic        use_pc;
    logic [4:0]  xrd;
    logic        xwe;
    logic [31:0] xres;
    logic [4:0]  wrd;
    logic        wwe;
    logic [31:0] wres;
    logic [11:0] ef;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] es;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    io.id_valid = 0; io.id_alu_f = 0; io.id_rs1_data = 0; io.id_rs2_data = 0;
    io.id_imm = 0; io.id_pc = 0; io.id_rs1 = 0; io.id_rs2 = 0; io.id_rd = 0;
    io.id_use_imm = 0; io.id_use_pc = 0; io.id_reg_we = 0; io.id_is_load = 0;
    io.stall = 0; io.flush = 0;
    io.exmem_rd = 0; io.exmem_we = 0; io.exmem_result = 0;
    io.memwb_rd = 0; io.memwb_we = 0; io.memwb_result = 0;
  endtask

  task automatic drive_id(input logic [11:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic use_imm, input logic is_load);
    io.id_valid = 1; io.id_alu_f = f; io.id_rs1 = rs1; io.id_rs2 = rs2; io.id_rd = rd;
    io.id_rs1_data = d1; io.id_rs2_data = d2; io.id_imm = 32'h0F0; io.id_pc = 0;
    io.id_use_imm = use_imm; io.id_use_pc = 0; io.id_reg_we = 1; io.id_is_load = is_load;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{12'h001, 5, 6, 'h11, 'h22, 0, 0, 0, 0, 5, 1, 'hAA, 0, 0, 0, 12'h001, 'hAA, 'h22, 'h22};
    vecs[1] = '{12'h002, 1, 7, 'h10, 'h33, 0, 0, 0, 0, 7, 1, 'h1, 7, 1, 'h2, 12'h002, 'h10, 'h1, 'h1};
    vecs[2] = '{12'h010, 0, 2, 0, 'h5, 0, 0, 0, 0, 0, 1, 'hFFFF_FFFF, 0, 0, 0, 12'h010, 0, 'h5, 'h5};
    vecs[3] = '{12'h020, 4, 9, 'h44, 'h99, 0, 0, 0, 0, 4, 0, 'hDEAD, 4, 1, 'hBEEF, 12'h020, 'hBEEF, 'h99, 'h99};
    vecs[4] = '{12'h040, 5, 7, 'h1, 'h77, 'h123, 'h1000, 1, 1, 7, 1, 'h700, 0, 0, 0, 12'h040, 'h1000, 'h123, 'h700};
    vecs[5] = '{12'h003, 8, 0, 'h8, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 'h8, 0, 0};
    vecs[6] = '{12'h000, 3, 4, 'h3, 'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 'h3, 'h4, 'h4};
    vecs[7] = '{12'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1234, 12'h800, 0, 0, 0};

    // Reset state
    idle();
    rst_n = 0;
    #1;
    chk("rst_ex_valid", io.ex_valid, 0);
    chk("rst_alu_f", io.alu_f, 0);
    chk("rst_ex_rd", io.ex_rd, 0);
    chk("rst_reg_we", io.ex_reg_we, 0);
    chk("rst_is_load", io.ex_is_load, 0);
    chk("rst_alu_a", io.alu_a, 0);
    chk("rst_store", io.ex_store_data, 0);
    @(posedge clk);
    #3;
    rst_n = 1;

    // Forwarding / operand-select table
    for (int i = 0; i < 8; i++) begin
      drive_id(vecs[i].f, vecs[i].rs1, vecs[i].rs2, 5'(10 + i), vecs[i].d1, vecs[i].d2,
               vecs[i].use_imm, 0);
      io.id_imm = vecs[i].imm;
      io.id_pc = vecs[i].pc;
      io.id_use_pc = vecs[i].use_pc;
      io.exmem_rd = vecs[i].xrd; io.exmem_we = vecs[i].xwe; io.exmem_result = vecs[i].xres;
      io.memwb_rd = vecs[i].wrd; io.memwb_we = vecs[i].wwe; io.memwb_result = vecs[i].wres;
      tick();
      chk($sformatf("v%0d_ex_valid", i), io.ex_valid, 1);
      chk($sformatf("v%0d_alu_f", i), io.alu_f, vecs[i].ef);
      chk($sformatf("v%0d_alu_a", i), io.alu_a, vecs[i].ea);
      chk($sformatf("v%0d_alu_b", i), io.alu_b, vecs[i].eb);
      chk($sformatf("v%0d_store", i), io.ex_store_data, vecs[i].es);
      chk($sformatf("v%0d_ex_rd", i), io.ex_rd, 10 + i);
    end

    // Load-use on rs1
    idle();
    drive_id(12'h001, 1, 2, 3, 0, 0, 0, 1);
    tick();
    chk("lu_ex_is_load", io.ex_is_load, 1);
    drive_id(12'h080, 3, 4, 6, 'h30, 'h40, 0, 0);
    #1;
    chk("lu_rs1_stall", io.load_use_stall, 1);
    tick();
    chk("lu_bubble_valid", io.ex_valid, 0);
    chk("lu_bubble_f", io.alu_f, 0);
    chk("lu_bubble_we", io.ex_reg_we, 0);
    chk("lu_stall_drop", io.load_use_stall, 0);
    tick();
    chk("lu_retry_valid", io.ex_valid, 1);
    chk("lu_retry_f", io.alu_f, 12'h080);
    chk("lu_retry_rd", io.ex_rd, 6);

    // Load-use on rs2 only counts when rs2 is really read
    drive_id(12'h001, 1, 2, 3, 0, 0, 0, 1);
    tick();
    drive_id(12'h020, 4, 3, 8, 0, 0, 1, 0);
    #1;
    chk("lu_rs2_imm", io.load_use_stall, 0);
    io.id_use_imm = 0;
    #1;
    chk("lu_rs2_reg", io.load_use_stall, 1);
    drive_id(12'h001, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive_id(12'h020, 0, 0, 5, 0, 0, 0, 0);
    #1;
    chk("lu_x0_load", io.load_use_stall, 0);

    // Flush wins over stall, then stall holds
    drive_id(12'h004, 1, 2, 7, 'h1, 'h2, 0, 0);
    tick();
    chk("fl_pre_valid", io.ex_valid, 1);
    io.stall = 1; io.flush = 1;
    tick();
    chk("fl_valid", io.ex_valid, 0);
    chk("fl_alu_f", io.alu_f, 0);
    io.stall = 0; io.flush = 0;
    drive_id(12'h020, 2, 0, 9, 'h2222, 0, 0, 0);
    tick();
    io.stall = 1;
    drive_id(12'h001, 3, 1, 11, 'h3333, 'h1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d_valid", c), io.ex_valid, 1);
      chk($sformatf("hold%0d_f", c), io.alu_f, 12'h020);
      chk($sformatf("hold%0d_a", c), io.alu_a, 'h2222);
      chk($sformatf("hold%0d_rd", c), io.ex_rd, 9);
    end

    // Async reset mid-cycle while a held instruction sits in EX
    #2;
    rst_n = 0;
    #1;
    chk("ar_valid", io.ex_valid, 0);
    chk("ar_alu_f", io.alu_f, 0);
    chk("ar_rd", io.ex_rd, 0);
    io.stall = 0;
    drive_id(12'h100, 1, 0, 12, 'h5, 0, 0, 0);
    tick();
    chk("ar_held_valid", io.ex_valid, 0);
    #2;
    rst_n = 1;
    tick();
    chk("ar_resume_valid", io.ex_valid, 1);
    chk("ar_resume_f", io.alu_f, 12'h100);
    chk("ar_resume_rd", io.ex_rd, 12);
    chk("ar_resume_a", io.alu_a, 'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter FW, default 12, meaning width of the one-hot ALU function code.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have decode-side inputs, all captured on the clock edge:
- id_valid 1: instruction present.
- id_alu_f FW: one-hot ALU function.
- id_rs1_data, id_rs2_data, id_imm, id_pc XLEN: operands, immediate, PC.
- id_rs1, id_rs2, id_rd 5: register specifiers.
- id_use_imm 1: operand b is the immediate.
- id_use_pc 1: operand a is the PC.
- id_reg_we 1: instruction writes rd.
- id_is_load 1: instruction is a load.
REQ-006 SHALL have control inputs stall 1 (hold stage) and flush 1 (kill stage contents).
REQ-007 SHALL have forwarding inputs:
- exmem_rd 5, exmem_we 1, exmem_result XLEN.
- memwb_rd 5, memwb_we 1, memwb_result XLEN.
REQ-008 SHALL have ALU-facing outputs alu_f FW, alu_a XLEN, alu_b XLEN.
REQ-009 SHALL have downstream outputs:
- ex_valid 1, ex_rd 5, ex_reg_we 1, ex_is_load 1.
- ex_store_data XLEN: forwarded rs2 value.
REQ-010 SHALL have output load_use_stall 1, a hazard request to the upstream stages.

Function
REQ-011 SHALL register all id_* fields when stall=0, flush=0 and load_use_stall=0.
REQ-012 SHALL load a bubble (valid=0, reg_we=0, is_load=0, f=0) when flush=1; flush SHALL take priority over stall.
REQ-013 SHALL hold all registered fields unchanged when stall=1 and flush=0.
REQ-014 SHALL load a bubble when load_use_stall=1 and stall=0 and flush=0.
REQ-015 SHALL assert load_use_stall combinationally when all of the following hold: ex_valid=1, ex_is_load=1, ex_rd!=0, id_valid=1, and (ex_rd==id_rs1, or ex_rd==id_rs2 with id_use_imm=0).
REQ-016 SHALL forward each source operand combinationally from the registered rs data:
- exmem_result if exmem_we=1, exmem_rd!=0 and exmem_rd equals the source register.
- else memwb_result under the same rule.
- else the registered rs data.
REQ-017 SHALL give the EX/MEM forwarding path priority over the MEM/WB path when both match.
REQ-018 SHALL never forward onto register x0; source register 0 SHALL always yield 0.
REQ-019 SHALL drive alu_a as registered PC when use_pc=1, else forwarded rs1.
REQ-020 SHALL drive alu_b as registered immediate when use_imm=1, else forwarded rs2.
REQ-021 SHALL drive ex_store_data as forwarded rs2 regardless of use_imm.
REQ-022 SHALL drive alu_f=0 whenever ex_valid=0, so the ALU default case produces y=0.
REQ-023 SHALL have latency of one cycle from id_* capture to alu_* validity, with zero added latency on the forwarding paths.
REQ-024 SHALL register alu_f only when it is one-hot or zero; any other value SHALL be captured as 0 with valid preserved.

Reset
REQ-025 SHALL, on rst_n low, immediately clear all state to 0: ex_valid=0, alu_f=0, ex_reg_we=0, ex_is_load=0, ex_rd=0, and all data registers 0.
REQ-026 SHALL, if reset is asserted mid-stall, discard the held instruction and resume capture on the first edge after rst_n rises.

Structure
REQ-027 SHALL take the one-hot ALU function constants (ADD, SUB, SLT, SLTU, AND, OR, NOR, XOR, SLL, SRL, SRA, EQ, NE, GE, GEU) and XLEN from a shared package cpu_pkg.
REQ-028 SHALL place the forwarding select logic in one sub-module fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-029 SHALL test EX/MEM forwarding:
- Stimulus: id_rs1=5, rs1_data=0x11, exmem_rd=5, we=1, result=0xAA.
- Response: alu_a=0xAA the next cycle.
REQ-030 SHALL test forwarding priority:
- Stimulus: exmem_rd=memwb_rd=7, results 0x1 and 0x2, source rs2=7, use_imm=0.
- Response: alu_b=0x1.
REQ-031 SHALL test x0 protection:
- Stimulus: rs1=0, exmem_rd=0, we=1, result=0xFFFF_FFFF.
- Response: alu_a=registered rs1 data (0).
REQ-032 SHALL test the load-use hazard:
- Stimulus: load to rd=3 in EX, id_rs1=3.
- Response: load_use_stall=1 for one cycle, then ex_valid=0 with alu_f=0.
REQ-033 SHALL test flush over stall:
- Stimulus: stall=1 and flush=1 together.
- Response: ex_valid=0 next cycle; with stall=1 alone, outputs are held for 3 cycles unchanged.
REQ-034 SHALL test asynchronous reset:
- Stimulus: rst_n low mid-cycle with ex_valid=1.
- Response: ex_valid=0 and alu_f=0 before the next clock edge.
